// File: rtl/beeb_1mhz_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beeb_1mhz_host_pkg
// Brief    : Shared types and constants for the BBC Micro 1MHz bus host.
// Revision : 1.0 - initial release
// ============================================================================
package beeb_1mhz_host_pkg;

    typedef enum logic [1:0] {
        KIND_JIM_MEM     = 2'd0,
        KIND_FRED        = 2'd1,
        KIND_JIM_RAW     = 2'd2,
        KIND_JIM_RAW_ALT = 2'd3
    } cmd_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAGE_HI  = 3'd1,
        ST_PAGE_MID = 3'd2,
        ST_ACCESS   = 3'd3,
        ST_DONE     = 3'd4
    } host_state_t;

    localparam logic [7:0] c_FRED_PAGE_HI   = 8'hFF;
    localparam logic [7:0] c_FRED_PAGE_MID  = 8'hFE;
    localparam logic [7:0] c_BUS_ADDR_IDLE  = 8'hFF;
    localparam logic [4:0] c_JIM_ID_DEFAULT = 5'b11001;

    function automatic logic is_fred_paging_reg(input logic [7:0] addr);
        return (addr == c_FRED_PAGE_HI) || (addr == c_FRED_PAGE_MID);
    endfunction

endpackage
`default_nettype wire

// File: rtl/beeb_1mhz_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : beeb_1mhz_phase_gen
// Brief    : Free-running 1MHz bus phase counter, clke and cycle strobes.
// Revision : 1.0 - initial release
// ============================================================================
module beeb_1mhz_phase_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_clke,
    output logic o_cycle_start,
    output logic o_sample
);

    localparam int              c_PW   = $clog2(CLK_DIV);
    localparam logic [c_PW-1:0] c_HALF = c_PW'(CLK_DIV / 2);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(CLK_DIV - 1);

    logic [c_PW-1:0] r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (r_phase == c_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_PW'(1);
        end
    end

    // cycle_start marks phase 0, so registers loaded on that edge change at phase 1
    assign o_clke        = (r_phase >= c_HALF);
    assign o_cycle_start = (r_phase == '0);
    assign o_sample      = (r_phase == c_LAST);

endmodule
`default_nettype wire

// File: rtl/beeb_1mhz_host.sv
`default_nettype none
// ============================================================================
// Module   : beeb_1mhz_host
// Brief    : 1MHz bus host issuing FRED/JIM cycles; optional JIM page cache
//            enabled by defining HOST_PAGE_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module beeb_1mhz_host
    import beeb_1mhz_host_pkg::*;
#(
    parameter int         CLK_DIV = 50,
    parameter logic [4:0] JIM_ID  = c_JIM_ID_DEFAULT
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_kind,
    input  logic        cmd_rnw,
    input  logic [18:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        clke,
    output logic        rnw,
    output logic        pgfc_n,
    output logic        pgfd_n,
    output logic [7:0]  bus_addr,
    inout  wire  [7:0]  bus_data
);

    host_state_t r_state, w_state_next, w_first, w_succ, w_bus_state;
    logic        r_launched, w_launched_next;
    logic        w_accept, w_bus_launch, w_hi_hit, w_mid_hit;
    logic        w_cycle_start, w_sample;
    cmd_kind_t   r_kind;
    logic        r_cmd_rnw, r_need_mid;
    logic [18:0] r_addr;
    logic [7:0]  r_cmd_wdata;
    logic        r_rnw, r_pgfc_n, r_pgfd_n, r_drive;
    logic [7:0]  r_bus_addr, r_bus_wdata, r_rdata;

    beeb_1mhz_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
        .clk           (clk50),
        .rst_n         (rst_n),
        .o_clke        (clke),
        .o_cycle_start (w_cycle_start),
        .o_sample      (w_sample)
    );

`ifdef HOST_PAGE_CACHE_EN
    // Mirror of the FCFF/FCFE paging registers as last written by this host
    logic       r_cache_valid;
    logic [2:0] r_cache_hi;
    logic [7:0] r_cache_mid;

    assign w_hi_hit  = r_cache_valid && (r_cache_hi == cmd_addr[18:16]);
    assign w_mid_hit = r_cache_valid && (r_cache_mid == cmd_addr[15:8]);

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_valid <= 1'b0;
            r_cache_hi    <= '0;
            r_cache_mid   <= '0;
        end else if (w_bus_launch) begin
            case (w_bus_state)
                ST_PAGE_HI:  r_cache_hi  <= r_addr[18:16];
                ST_PAGE_MID: r_cache_mid <= r_addr[15:8];
                ST_ACCESS: begin
                    if (r_kind == KIND_JIM_MEM) begin
                        r_cache_valid <= 1'b1;
                    end else if (r_kind == KIND_FRED && !r_cmd_rnw && is_fred_paging_reg(r_addr[7:0])) begin
                        r_cache_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign w_hi_hit  = 1'b0;
    assign w_mid_hit = 1'b0;
`endif

    always_comb begin
        w_first = ST_ACCESS;
        if (cmd_kind_t'(cmd_kind) == KIND_JIM_MEM) begin
            if (!w_hi_hit) begin
                w_first = ST_PAGE_HI;
            end else if (!w_mid_hit) begin
                w_first = ST_PAGE_MID;
            end
        end
    end

    always_comb begin
        case (r_state)
            ST_PAGE_HI:  w_succ = r_need_mid ? ST_PAGE_MID : ST_ACCESS;
            ST_PAGE_MID: w_succ = ST_ACCESS;
            default:     w_succ = ST_DONE;
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_launched <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_launched <= w_launched_next;
        end
    end

    // A busy state is first entered unlaunched; its bus cycle starts at the next phase 1
    always_comb begin
        w_state_next    = r_state;
        w_launched_next = r_launched;
        w_accept        = 1'b0;
        w_bus_launch    = 1'b0;
        w_bus_state     = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept        = 1'b1;
                    w_state_next    = w_first;
                    w_launched_next = 1'b0;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: begin
                if (w_cycle_start) begin
                    w_bus_launch = 1'b1;
                    if (!r_launched) begin
                        w_launched_next = 1'b1;
                        w_bus_state     = r_state;
                    end else begin
                        w_state_next = w_succ;
                        w_bus_state  = w_succ;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_kind      <= KIND_JIM_MEM;
            r_cmd_rnw   <= 1'b1;
            r_addr      <= '0;
            r_cmd_wdata <= '0;
            r_need_mid  <= 1'b0;
        end else if (w_accept) begin
            r_kind      <= cmd_kind_t'(cmd_kind);
            r_cmd_rnw   <= cmd_rnw;
            r_addr      <= cmd_addr;
            r_cmd_wdata <= cmd_wdata;
            r_need_mid  <= (cmd_kind_t'(cmd_kind) == KIND_JIM_MEM) && !w_mid_hit;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_rnw       <= 1'b1;
            r_pgfc_n    <= 1'b1;
            r_pgfd_n    <= 1'b1;
            r_bus_addr  <= c_BUS_ADDR_IDLE;
            r_bus_wdata <= '0;
            r_drive     <= 1'b0;
        end else if (w_bus_launch) begin
            r_rnw      <= 1'b1;
            r_pgfc_n   <= 1'b1;
            r_pgfd_n   <= 1'b1;
            r_bus_addr <= c_BUS_ADDR_IDLE;
            r_drive    <= 1'b0;
            case (w_bus_state)
                ST_PAGE_HI: begin
                    r_rnw       <= 1'b0;
                    r_pgfc_n    <= 1'b0;
                    r_bus_addr  <= c_FRED_PAGE_HI;
                    r_bus_wdata <= {JIM_ID, r_addr[18:16]};
                    r_drive     <= 1'b1;
                end
                ST_PAGE_MID: begin
                    r_rnw       <= 1'b0;
                    r_pgfc_n    <= 1'b0;
                    r_bus_addr  <= c_FRED_PAGE_MID;
                    r_bus_wdata <= r_addr[15:8];
                    r_drive     <= 1'b1;
                end
                ST_ACCESS: begin
                    r_rnw       <= r_cmd_rnw;
                    r_bus_addr  <= r_addr[7:0];
                    r_bus_wdata <= r_cmd_wdata;
                    r_drive     <= !r_cmd_rnw;
                    if (r_kind == KIND_FRED) begin
                        r_pgfc_n <= 1'b0;
                    end else begin
                        r_pgfd_n <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only a launched read ACCESS samples; an unlaunched one still shows idle rnw=1
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_sample && r_state == ST_ACCESS && r_launched && r_rnw) begin
            r_rdata <= bus_data;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_rdata = r_rdata;
    assign rnw       = r_rnw;
    assign pgfc_n    = r_pgfc_n;
    assign pgfd_n    = r_pgfd_n;
    assign bus_addr  = r_bus_addr;
    assign bus_data  = r_drive ? r_bus_wdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_beeb_1mhz_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_beeb_1mhz_host
// Brief    : Directed self-checking bench for beeb_1mhz_host with a bus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beeb_1mhz_host;

    localparam int DIV = 50;
`ifdef HOST_PAGE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct packed {
        logic       fc;
        logic       fd;
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] data;
    } cyc_t;

    logic        clk50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_kind = 2'd0;
    logic        cmd_rnw = 1'b1;
    logic [18:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    wire         cmd_ready, rsp_valid, clke, rnw, pgfc_n, pgfd_n;
    wire  [7:0]  rsp_rdata, bus_addr;
    wire  [7:0]  bus_data;

    int          tb_phase;
    logic [7:0]  rd_byte = 8'h00;
    logic        w_tb_drive;
    int          total = 0, bad = 0, viol = 0, rsp_cnt = 0, seen_cycles = 0;
    cyc_t        log_q[$];
    cyc_t        exp_q[$];
    logic [10:0] prev_bus = '1;
    logic        prev_write = 1'b0, rst_seen_hi = 1'b0;
    logic        m_sel, m_wr, m_exp_drv, m_dut_drv;

    beeb_1mhz_host #(.CLK_DIV(DIV), .JIM_ID(5'b11001)) dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_rnw   (cmd_rnw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .clke      (clke),
        .rnw       (rnw),
        .pgfc_n    (pgfc_n),
        .pgfd_n    (pgfd_n),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) tb_phase <= 0;
        else        tb_phase <= (tb_phase == DIV - 1) ? 0 : tb_phase + 1;
    end

    // Responder: read data is only correct during the last clke-high clock
    assign w_tb_drive = rnw && (!pgfc_n || !pgfd_n);
    assign bus_data   = w_tb_drive ? ((tb_phase == DIV - 1) ? rd_byte : ~rd_byte) : 8'hzz;

    always @(negedge clk50) begin
        m_sel = !pgfc_n || !pgfd_n;
        m_wr  = m_sel && !rnw;
        if (rst_n && rst_seen_hi) begin
            if (clke !== (tb_phase >= DIV / 2)) viol++;
            if ({rnw, pgfc_n, pgfd_n, bus_addr} !== prev_bus && tb_phase != 1) viol++;
            m_exp_drv = (tb_phase == 0) ? prev_write : m_wr;
            m_dut_drv = (bus_data !== 8'hzz);
            if (!w_tb_drive && m_dut_drv !== m_exp_drv) viol++;
            if (tb_phase == DIV - 1) begin
                if (m_sel) log_q.push_back(cyc_t'({!pgfc_n, !pgfd_n, rnw, bus_addr, bus_data}));
                prev_write = m_wr;
            end
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (tb_phase != 1) viol++;
            end
        end else begin
            prev_write = 1'b0;
        end
        prev_bus    = {rnw, pgfc_n, pgfd_n, bus_addr};
        rst_seen_hi = rst_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cyc_t mk(input logic fc, input logic fd, input logic r,
                                input logic [7:0] a, input logic [7:0] d);
        return cyc_t'({fc, fd, r, a, d});
    endfunction

    task automatic check_log(input string tag);
        seen_cycles += log_q.size();
        chk({tag, "_ncyc"}, log_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            chk($sformatf("%s_cyc%0d", tag, i),
                (i < log_q.size()) ? {13'd0, log_q[i]} : 32'hFFFF_FFFF, {13'd0, exp_q[i]});
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] k, input logic r,
                          input logic [18:0] a, input logic [7:0] wd, input logic [7:0] rb);
        int c0, n;
        c0      = rsp_cnt;
        rd_byte = rb;
        @(posedge clk50); #2;
        cmd_kind = k; cmd_rnw = r; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
        @(posedge clk50); #2;
        chk({tag, "_busy"}, {31'd0, cmd_ready}, 32'd0);
        // A would-be FCFF write while busy must be dropped
        cmd_kind = 2'd1; cmd_rnw = 1'b0; cmd_addr = 19'h000FF; cmd_wdata = 8'h00;
        repeat (3) @(posedge clk50);
        #2;
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_cnt == c0 && n < 6 * DIV) begin
            @(posedge clk50); #2;
            n++;
        end
        repeat (DIV) @(posedge clk50);
        #2;
        chk({tag, "_rsp"}, rsp_cnt - c0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_clke", {31'd0, clke}, 32'd0);
        chk("rst_bus_ctl", {29'd0, pgfc_n, pgfd_n, rnw}, 32'h7);
        chk("rst_bus_addr", {24'd0, bus_addr}, 32'hFF);
        chk("rst_bus_data_z", {31'd0, (bus_data === 8'hzz)}, 32'd1);
        @(posedge clk50); #2;
        rst_n = 1'b1;
        repeat (2 * DIV) @(posedge clk50);
        #2;
        chk("idle_no_cycles", log_q.size(), 32'd0);

        // Kind 0 write: full paging sequence
        exp_q.push_back(mk(1, 0, 0, 8'hFF, 8'hCD));
        exp_q.push_back(mk(1, 0, 0, 8'hFE, 8'h12));
        exp_q.push_back(mk(0, 1, 0, 8'h34, 8'hA5));
        do_cmd("wr51234", 2'd0, 1'b0, 19'h5_1234, 8'hA5, 8'h00);
        check_log("wr51234");

        // Two same-page reads
        seen_cycles = 0;
        if (!CACHE) begin
            exp_q.push_back(mk(1, 0, 0, 8'hFF, 8'hCD));
            exp_q.push_back(mk(1, 0, 0, 8'hFE, 8'h12));
        end
        exp_q.push_back(mk(0, 1, 1, 8'h35, 8'h3C));
        do_cmd("rd51235", 2'd0, 1'b1, 19'h5_1235, 8'h00, 8'h3C);
        check_log("rd51235");
        chk("rd51235_data", {24'd0, rsp_rdata}, 32'h3C);
        if (!CACHE) begin
            exp_q.push_back(mk(1, 0, 0, 8'hFF, 8'hCD));
            exp_q.push_back(mk(1, 0, 0, 8'hFE, 8'h12));
        end
        exp_q.push_back(mk(0, 1, 1, 8'h36, 8'h5A));
        do_cmd("rd51236", 2'd0, 1'b1, 19'h5_1236, 8'h00, 8'h5A);
        check_log("rd51236");
        chk("rd51236_data", {24'd0, rsp_rdata}, 32'h5A);
        chk("two_reads_cycles", seen_cycles, CACHE ? 32'd2 : 32'd6);

        // Unrelated FRED write keeps cache; FCFE write drops it
        exp_q.push_back(mk(1, 0, 0, 8'hA0, 8'h80));
        do_cmd("fredA0", 2'd1, 1'b0, 19'h000A0, 8'h80, 8'h00);
        check_log("fredA0");
        chk("fredA0_keep_rdata", {24'd0, rsp_rdata}, 32'h5A);
        if (!CACHE) begin
            exp_q.push_back(mk(1, 0, 0, 8'hFF, 8'hCD));
            exp_q.push_back(mk(1, 0, 0, 8'hFE, 8'h12));
        end
        exp_q.push_back(mk(0, 1, 1, 8'h37, 8'h11));
        do_cmd("rd51237", 2'd0, 1'b1, 19'h5_1237, 8'h00, 8'h11);
        check_log("rd51237");
        exp_q.push_back(mk(1, 0, 0, 8'hFE, 8'h12));
        do_cmd("fredFE", 2'd1, 1'b0, 19'h000FE, 8'h12, 8'h00);
        check_log("fredFE");
        exp_q.push_back(mk(1, 0, 0, 8'hFF, 8'hCD));
        exp_q.push_back(mk(1, 0, 0, 8'hFE, 8'h12));
        exp_q.push_back(mk(0, 1, 1, 8'h38, 8'h22));
        do_cmd("rd51238", 2'd0, 1'b1, 19'h5_1238, 8'h00, 8'h22);
        check_log("rd51238");
        chk("rd51238_data", {24'd0, rsp_rdata}, 32'h22);

        // Raw JIM page read and kind 3 write
        exp_q.push_back(mk(0, 1, 1, 8'h77, 8'h99));
        do_cmd("jim77", 2'd2, 1'b1, 19'h00077, 8'h00, 8'h99);
        check_log("jim77");
        chk("jim77_data", {24'd0, rsp_rdata}, 32'h99);
        exp_q.push_back(mk(0, 1, 0, 8'h10, 8'h55));
        do_cmd("kind3wr", 2'd3, 1'b0, 19'h00010, 8'h55, 8'h00);
        check_log("kind3wr");
        chk("kind3wr_keep_rdata", {24'd0, rsp_rdata}, 32'h99);

        // Reset while the FCFE cycle is on the bus
        @(posedge clk50); #2;
        cmd_kind = 2'd0; cmd_rnw = 1'b0; cmd_addr = 19'h2_ABCD; cmd_wdata = 8'hEE; cmd_valid = 1'b1;
        @(posedge clk50); #2;
        cmd_valid = 1'b0;
        c0 = rsp_cnt;
        n  = 0;
        while (!(pgfc_n === 1'b0 && bus_addr === 8'hFE) && n < 4 * DIV) begin
            @(posedge clk50); #2;
            n++;
        end
        chk("abort_reached_mid", {24'd0, bus_addr}, 32'hFE);
        repeat (5) @(posedge clk50);
        #2;
        rst_n = 1'b0;
        @(negedge clk50);
        chk("abort_bus_ctl", {29'd0, pgfc_n, pgfd_n, rnw}, 32'h7);
        chk("abort_bus_addr", {24'd0, bus_addr}, 32'hFF);
        chk("abort_bus_data_z", {31'd0, (bus_data === 8'hzz)}, 32'd1);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (3) @(posedge clk50);
        #2;
        rst_n = 1'b1;
        repeat (4 * DIV) @(posedge clk50);
        #2;
        chk("abort_no_rsp", rsp_cnt - c0, 32'd0);
        log_q.delete();
        exp_q.push_back(mk(1, 0, 0, 8'hFF, 8'hCA));
        exp_q.push_back(mk(1, 0, 0, 8'hFE, 8'hAB));
        exp_q.push_back(mk(0, 1, 0, 8'hCD, 8'hEE));
        do_cmd("retry2ABCD", 2'd0, 1'b0, 19'h2_ABCD, 8'hEE, 8'h00);
        check_log("retry2ABCD");

        chk("timing_violations", viol, 32'd0);
        chk("rsp_pulses_total", rsp_cnt, 32'd10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
